// File: rtl/seg_pkg.sv
// Shared constants and nibble/select helpers for the 4-digit 7-segment scanner.
package seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int NIB_W      = 4;
   localparam int SEL_W      = NUM_DIGITS;
   localparam int VAL_W      = NIB_W * NUM_DIGITS;

   localparam logic [SEL_W-1:0] SEL_OFF = 4'b1111;

   typedef logic [1:0] idx_t;

   function automatic logic [SEL_W-1:0] sel_onehot(input idx_t i);
      return ~(4'b0001 << i);
   endfunction

   function automatic logic [NIB_W-1:0] nibble_at(input logic [VAL_W-1:0] v, input idx_t i);
      logic [NIB_W-1:0] n;
      case (i)
         2'd0:    n = v[3:0];
         2'd1:    n = v[7:4];
         2'd2:    n = v[11:8];
         2'd3:    n = v[15:12];
         default: n = v[3:0];
      endcase
      return n;
   endfunction

   // True when this digit and every digit to its left are zero; the rightmost digit never qualifies.
   function automatic logic lead_zero(input logic [VAL_W-1:0] v, input idx_t i);
      logic z;
      case (i)
         2'd1:    z = (v[15:4] == 12'h000);
         2'd2:    z = (v[15:8] == 8'h00);
         2'd3:    z = (v[15:12] == 4'h0);
         default: z = 1'b0;
      endcase
      return z;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Slot prescaler: counts 0..DIV-1 and exposes the next count plus the wrap condition.
module tick_gen #(
   parameter int DIV = 50000,
   parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [CW-1:0] ncnt,
   output logic          wrap
);

   logic [CW-1:0] cnt_r;

   // next-count and wrap decode
   always_comb begin
      wrap = (cnt_r == CW'(DIV - 1));
      if (wrap) begin
         ncnt = '0;
      end else begin
         ncnt = cnt_r + CW'(1);
      end
   end

   // prescaler state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= ncnt;
      end
   end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit scanner: snapshots a 16-bit value and presents one nibble,
// an active-low digit select and a leading-zero blank flag per slot.
module seg_scan
   import seg_pkg::*;
#(
   parameter int DIV  = 50000,
   parameter int DEAD = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        lzb_en,
   output logic [3:0]  digit,
   output logic [3:0]  sel,
   output logic        blank,
   output logic        scan_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [SEL_W-1:0] SEL_RST = (DEAD > 0) ? SEL_OFF : 4'b1110;

   logic [CW-1:0]    ncnt_s;
   logic             wrap_s;
   idx_t             idx_r;
   idx_t             nidx_s;
   logic             dead_s;
   logic [VAL_W-1:0] value_q_r;

   tick_gen #(
      .DIV (DIV),
      .CW  (CW)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .ncnt  (ncnt_s),
      .wrap  (wrap_s)
   );

   // next digit index and dead-time window, both from the prescaler's next state
   always_comb begin
      if (wrap_s) begin
         nidx_s = idx_r + 2'd1;
      end else begin
         nidx_s = idx_r;
      end
      dead_s = ((32'(ncnt_s) + 32'd1) <= 32'(DEAD));
   end

   // digit index, snapshot and registered outputs aligned with the next slot state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r     <= 2'd0;
         value_q_r <= 16'h0000;
         digit     <= 4'h0;
         sel       <= SEL_RST;
         blank     <= 1'b0;
         scan_tick <= 1'b0;
      end else begin
         idx_r <= nidx_s;
         if (load) begin
            value_q_r <= value;
         end else begin
            value_q_r <= value_q_r;
         end
         // outputs use the pre-load snapshot, so a reload shows up one edge later
         digit     <= nibble_at(value_q_r, nidx_s);
         sel       <= dead_s ? SEL_OFF : sel_onehot(nidx_s);
         blank     <= lzb_en && lead_zero(value_q_r, nidx_s);
         scan_tick <= (ncnt_s == '0);
      end
   end

endmodule
